// File: rtl/isa_pkg.sv
// Shared ISA definitions for the multicycle core: opcodes, instruction field
// positions and the fetch unit state encoding.
package isa_pkg;

  localparam logic [3:0] OP_RTYPE = 4'd0;
  localparam logic [3:0] OP_LW    = 4'd1;
  localparam logic [3:0] OP_BEQ   = 4'd2;
  localparam logic [3:0] OP_ORI   = 4'd3;
  localparam logic [3:0] OP_SW    = 4'd4;
  localparam logic [3:0] OP_ANDI  = 4'd5;
  localparam logic [3:0] OP_ADDI  = 4'd6;
  localparam logic [3:0] OP_SLTI  = 4'd7;
  localparam logic [3:0] OP_JUMP  = 4'd8;
  localparam logic [3:0] OP_HALT  = 4'd15;

  // Field positions inside a 16-bit instruction word.
  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int JT_MSB   = 11;
  localparam int JT_LSB   = 0;
  localparam int BOFF_MSB = 3;
  localparam int BOFF_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } fetchState_t;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection for a retiring, non-halting instruction:
// jump target, taken BEQ (pc + 1 + signed 4-bit offset) or sequential pc + 1.
// All arithmetic wraps modulo 2^PC_W.
module pc_next_calc
  import isa_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int PC_W    = 12
) (
  input  logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr,
  input  logic               jump,
  input  logic               branch,
  input  logic               aluZero,
  output logic [PC_W-1:0]    pcNext
);

  logic [31:0]                      jumpWide;
  logic [PC_W-1:0]                  jumpTarget;
  logic signed [BOFF_MSB-BOFF_LSB:0] brOff;
  logic [PC_W-1:0]                  brOffExt;
  logic                             unusedBits;

  // Jump target is zero-extended (or truncated) to PC_W; the branch offset
  // is sign-extended so a negative offset wraps backwards.
  always_comb begin
    jumpWide   = 32'(instr[JT_MSB:JT_LSB]);
    jumpTarget = jumpWide[PC_W-1:0];
    brOff      = instr[BOFF_MSB:BOFF_LSB];
    brOffExt   = PC_W'(brOff);
    unusedBits = ^{instr[INSTR_W-1:JT_MSB+1], jumpWide[31:PC_W]};
    if (jump) begin
      pcNext = jumpTarget;
    end else if (branch && aluZero) begin
      pcNext = pc + PC_W'(1) + brOffExt;
    end else begin
      pcNext = pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Front end of the multicycle core: owns the PC, fetches an instruction from
// imem, issues it to the decoder for one EXEC phase and selects the next PC
// from the decoder's jump/branch/halt outputs and the ALU zero flag.
module instr_fetch_unit
  import isa_pkg::*;
#(
  parameter int          INSTR_W  = 16,
  parameter int          PC_W     = 12,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               imemReq,
  output logic [PC_W-1:0]    imemAddr,
  input  logic               imemValid,
  input  logic [INSTR_W-1:0] imemData,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         opCode,
  output logic               instrValid,
  input  logic               execDone,
  input  logic               jump,
  input  logic               branch,
  input  logic               aluZero,
  input  logic               halt,
  output logic [PC_W-1:0]    pc,
  output logic               halted
);

  fetchState_t     state;
  fetchState_t     stateNext;
  logic            loadInstr;
  logic            updatePc;
  logic [PC_W-1:0] pcNext;

  pc_next_calc #(
    .INSTR_W (INSTR_W),
    .PC_W    (PC_W)
  ) uPcNext (
    .pc      (pc),
    .instr   (instr),
    .jump    (jump),
    .branch  (branch),
    .aluZero (aluZero),
    .pcNext  (pcNext)
  );

  // Outputs decoded straight from state so reset drops imemReq immediately.
  assign imemReq  = (state == ST_FETCH);
  assign halted   = (state == ST_HALTED);
  assign imemAddr = pc;
  assign opCode   = instr[OPC_MSB:OPC_LSB];

  // Next-state and datapath enables; inputs are only honoured in their own state.
  always_comb begin
    stateNext = state;
    loadInstr = 1'b0;
    updatePc  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) stateNext = ST_FETCH;
      end
      ST_FETCH: begin
        if (imemValid) begin
          loadInstr = 1'b1;
          stateNext = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (execDone) begin
          if (halt) begin
            stateNext = ST_HALTED;
          end else begin
            updatePc  = 1'b1;
            stateNext = ST_FETCH;
          end
        end
      end
      ST_HALTED: begin
        stateNext = ST_HALTED;
      end
      default: begin
        stateNext = ST_IDLE;
      end
    endcase
  end

  // State, PC and instruction registers; instrValid marks the first EXEC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pc         <= PC_W'(RESET_PC);
      instr      <= '0;
      instrValid <= 1'b0;
    end else begin
      state      <= stateNext;
      instrValid <= loadInstr;
      if (loadInstr) instr <= imemData;
      if (updatePc)  pc    <= pcNext;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized self-checking bench for instr_fetch_unit with a transaction-level
// reference model of the program counter and a behavioural imem.
module tb_instr_fetch_unit;
  import isa_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        imemReq;
  logic [11:0] imemAddr;
  logic        imemValid;
  logic [15:0] imemData;
  logic [15:0] instr;
  logic [3:0]  opCode;
  logic        instrValid;
  logic        execDone;
  logic        jump;
  logic        branch;
  logic        aluZero;
  logic        halt;
  logic [11:0] pc;
  logic        halted;

  logic [15:0] mem [4096];
  int          modelPc;
  int          vectors = 0;
  int          miscompares = 0;

  instr_fetch_unit #(
    .INSTR_W  (16),
    .PC_W     (12),
    .RESET_PC (0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .imemReq    (imemReq),
    .imemAddr   (imemAddr),
    .imemValid  (imemValid),
    .imemData   (imemData),
    .instr      (instr),
    .opCode     (opCode),
    .instrValid (instrValid),
    .execDone   (execDone),
    .jump       (jump),
    .branch     (branch),
    .aluZero    (aluZero),
    .halt       (halt),
    .pc         (pc),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkVal({tag, ".imemReq"},    32'(imemReq),    32'd0);
    checkVal({tag, ".instrValid"}, 32'(instrValid), 32'd0);
    checkVal({tag, ".halted"},     32'(halted),     32'd0);
    checkVal({tag, ".pc"},         32'(pc),         32'd0);
    checkVal({tag, ".instr"},      32'(instr),      32'd0);
    checkVal({tag, ".opCode"},     32'(opCode),     32'd0);
  endtask

  task automatic checkFetch();
    checkVal("fetch.imemReq",    32'(imemReq),    32'd1);
    checkVal("fetch.imemAddr",   32'(imemAddr),   32'(modelPc));
    checkVal("fetch.instrValid", 32'(instrValid), 32'd0);
    checkVal("fetch.halted",     32'(halted),     32'd0);
  endtask

  // Asserts rst_n between clock edges and checks outputs before any edge.
  task automatic asyncReset(input string tag);
    #2 rst_n = 1'b0;
    #1 checkResetOutputs(tag);
    @(negedge clk);
    rst_n     = 1'b1;
    start     = 1'b0;
    imemValid = 1'b0;
    execDone  = 1'b0;
    {jump, branch, aluZero, halt} = 4'b0;
    modelPc   = 0;
  endtask

  // Called at a negedge while idle; leaves the core in its first FETCH cycle.
  task automatic startCore();
    checkVal("idle.imemReq", 32'(imemReq), 32'd0);
    imemValid = 1'b1;
    execDone  = 1'b1;
    nextCycle();
    checkVal("idle.stay", 32'(imemReq), 32'd0);
    imemValid = 1'b0;
    execDone  = 1'b0;
    start     = 1'b1;
    nextCycle();
    start     = 1'b0;
  endtask

  // One complete instruction, starting at a negedge inside FETCH.
  task automatic runInstr(input int fetchWait, input int execWait,
                          input bit j, input bit b, input bit z, input bit h);
    logic [15:0] word;
    int          off;
    for (int k = 0; k < fetchWait; k++) begin
      checkFetch();
      imemValid = 1'b0;
      imemData  = 16'($urandom);
      execDone  = 1'($urandom % 2);
      start     = 1'($urandom % 2);
      nextCycle();
    end
    checkFetch();
    word      = mem[modelPc];
    imemValid = 1'b1;
    imemData  = word;
    execDone  = 1'($urandom % 2);
    start     = 1'($urandom % 2);
    nextCycle();
    imemData  = 16'($urandom);
    checkVal("exec.instrValid", 32'(instrValid), 32'd1);
    checkVal("exec.instr",      32'(instr),      32'(word));
    checkVal("exec.opCode",     32'(opCode),     32'(word[15:12]));
    checkVal("exec.pc",         32'(pc),         32'(modelPc));
    checkVal("exec.imemReq",    32'(imemReq),    32'd0);
    for (int k = 0; k <= execWait; k++) begin
      if (k > 0) begin
        checkVal("execWait.instrValid", 32'(instrValid), 32'd0);
        checkVal("execWait.imemReq",    32'(imemReq),    32'd0);
        checkVal("execWait.pc",         32'(pc),         32'(modelPc));
      end
      execDone  = (k == execWait);
      if (k == execWait) {jump, branch, aluZero, halt} = {j, b, z, h};
      else               {jump, branch, aluZero, halt} = 4'($urandom);
      imemValid = 1'($urandom % 2);
      start     = 1'($urandom % 2);
      nextCycle();
    end
    execDone  = 1'b0;
    imemValid = 1'b0;
    start     = 1'b0;
    {jump, branch, aluZero, halt} = 4'b0;
    if (!h) begin
      if (j) begin
        modelPc = int'(word[11:0]);
      end else if (b && z) begin
        off     = word[3] ? int'(word[3:0]) - 16 : int'(word[3:0]);
        modelPc = (modelPc + 1 + off) & 'hFFF;
      end else begin
        modelPc = (modelPc + 1) & 'hFFF;
      end
    end
    checkVal("retire.halted", 32'(halted), h ? 32'd1 : 32'd0);
    checkVal("retire.pc",     32'(pc),     32'(modelPc));
  endtask

  initial begin
    int fw;
    int ew;
    rst_n     = 1'b0;
    start     = 1'b0;
    imemValid = 1'b0;
    imemData  = '0;
    execDone  = 1'b0;
    {jump, branch, aluZero, halt} = 4'b0;
    modelPc   = 0;
    for (int a = 0; a < 4096; a++) mem[a] = 16'($urandom);
    mem[0]     = {OP_ADDI, 12'h011};
    mem[1]     = {OP_ADDI, 12'h022};
    mem[2]     = {OP_ADDI, 12'h033};
    mem[3]     = 16'h80A5;
    mem[12'hA5] = {OP_JUMP, 12'h00A};
    mem[10]    = {OP_BEQ, 12'h00E};
    mem[9]     = {OP_JUMP, 12'h00A};
    mem[11]    = {OP_JUMP, 12'hFFF};
    mem[12'hFFF] = {OP_ADDI, 12'h001};

    #1 checkResetOutputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    nextCycle();

    startCore();
    runInstr(0, 0, 0, 0, 0, 0);
    runInstr(0, 0, 0, 0, 0, 0);
    runInstr(0, 0, 0, 0, 0, 0);
    checkVal("seq.pc3", 32'(pc), 32'd3);
    runInstr(0, 0, 1, 0, 0, 0);
    checkVal("jump.target", 32'(imemAddr), 32'h0A5);
    runInstr(0, 1, 1, 0, 0, 0);
    runInstr(0, 0, 0, 1, 1, 0);
    checkVal("beq.taken", 32'(pc), 32'd9);
    runInstr(0, 2, 1, 0, 0, 0);
    runInstr(1, 0, 0, 1, 0, 0);
    checkVal("beq.notTaken", 32'(pc), 32'd11);
    runInstr(0, 0, 1, 1, 1, 0);
    checkVal("jump.max", 32'(pc), 32'hFFF);
    runInstr(3, 0, 0, 0, 0, 0);
    checkVal("wrap.addr", 32'(imemAddr), 32'd0);

    for (int n = 0; n < 200; n++) begin
      fw = ($urandom % 3 == 0) ? int'($urandom % 4) : 0;
      ew = ($urandom % 3 == 0) ? int'($urandom % 3) : 0;
      runInstr(fw, ew, 1'($urandom % 5 == 0), 1'($urandom % 2), 1'($urandom % 2), 1'b0);
    end

    mem[modelPc] = {OP_HALT, 12'h000};
    runInstr(int'($urandom % 2), int'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2), 1'b1, 1'b1);
    for (int k = 0; k < 20; k++) begin
      checkVal("halt.imemReq", 32'(imemReq),    32'd0);
      checkVal("halt.halted",  32'(halted),     32'd1);
      checkVal("halt.pc",      32'(pc),         32'(modelPc));
      checkVal("halt.valid",   32'(instrValid), 32'd0);
      start     = 1'($urandom % 2);
      imemValid = 1'($urandom % 2);
      execDone  = 1'($urandom % 2);
      nextCycle();
    end
    start     = 1'b0;
    imemValid = 1'b0;
    execDone  = 1'b0;

    asyncReset("rstHalted");
    startCore();
    runInstr(0, 0, 0, 0, 0, 0);
    runInstr(0, 1, 0, 0, 0, 0);
    checkFetch();
    asyncReset("rstFetch");
    startCore();
    runInstr(2, 0, 0, 0, 0, 0);
    checkFetch();
    imemValid = 1'b1;
    imemData  = mem[modelPc];
    nextCycle();
    imemValid = 1'b0;
    checkVal("preRst.instrValid", 32'(instrValid), 32'd1);
    asyncReset("rstExec");
    startCore();
    runInstr(0, 0, 0, 0, 0, 0);
    checkVal("restart.pc", 32'(pc), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
